id_ex_stage_reg: RTL and testbench
==================================

// Module: id_ex_stage_reg
// PURPOSE
//  ID/EX pipeline register with load-use hazard detection and branch flush. Captures the decode
//  control word (result_src, mem_write, reg_write, jmp, branch, alu_op, alu_src_opa/opb) and the
//  decode datapath (rd1, rd2, pc, pc+4, imm_ext, rs1, rs2, rd, funct3, funct7b5) for EX.
//  Generates fetch/decode stalls and the decode flush, and counts inserted bubbles.
// PARAMETERS
//  XLEN      32  datapath width for rd1, rd2, pc, pc_plus4, imm_ext
//  CNT_W     16  width of the saturating bubble counter
// PORTS
//  i_clk            in   1      clock, rising edge
//  i_rst_n          in   1      asynchronous active-low reset
//  i_result_src     in   2      decode control word fields, from the control unit
//  i_mem_write, i_reg_write, i_jmp, i_branch  in  1 each
//  i_alu_op         in   3
//  i_alu_src_opa    in   2
//  i_alu_src_opb    in   1
//  i_rd1, i_rd2     in   XLEN   register file read data
//  i_pc, i_pc_plus4, i_imm_ext  in  XLEN
//  i_rs1, i_rs2, i_rd  in  5    register indices of the decode instruction
//  i_funct3         in   3 ;  i_funct7b5  in  1
//  i_ex_pc_src      in   1      EX resolved taken branch/jump: flush younger stages
//  i_ex_hold        in   1      EX cannot advance (memory wait): freeze ID/EX
//  o_*              out  same   registered copies of every i_* decode field above
//  o_valid          out  1      ID/EX holds a real instruction (0 = bubble)
//  o_stall_f        out  1      hold PC (combinational)
//  o_stall_d        out  1      hold IF/ID (combinational)
//  o_flush_d        out  1      clear IF/ID to a bubble (combinational) = i_ex_pc_src
//  o_bubble_cnt     out  CNT_W  saturating count of bubbles from load-use hazards
// BEHAVIOUR
//  Reset (i_rst_n=0, async): all o_* register fields 0, o_valid 0, o_bubble_cnt 0.
//  Bubble = control fields result_src..alu_src_opb all 0, data fields all 0, o_valid 0
//   (matches the control unit's default 15'b0 word: no reg/mem write, no jmp/branch).
//  load_use = o_valid & (o_result_src==2'b01) & (o_rd!=0) & ((o_rd==i_rs1)|(o_rd==i_rs2)).
//  Rising-edge update, priority highest first:
//   1 i_ex_pc_src=1 : load bubble (flush wins over hold and load_use).
//   2 i_ex_hold=1   : keep all registers unchanged.
//   3 load_use=1    : load bubble; o_bubble_cnt += 1, saturating at all-ones.
//   4 otherwise     : capture all i_* fields, o_valid <= 1.
//  o_stall_f = o_stall_d = (load_use | i_ex_hold) & ~i_ex_pc_src.
//  o_flush_d = i_ex_pc_src. Latency ID->EX: exactly 1 cycle when not stalled.
//  A load-use stalls exactly one cycle: after the bubble, o_result_src=0 so load_use drops and
//   the held decode instruction is captured the next edge.
//  rs1/rs2 compared even for formats not using them (false stall permitted, never a missed one).
//  Reset deasserted mid-stall: registers restart from the bubble; no stale stall survives.
// TESTING
//  Reset: drive random inputs with i_rst_n=0 -> all outputs 0, o_stall_f/d=0, o_valid=0.
//  Pass-through: addi x5 fields, rd1=0x11 -> next edge o_rd=5, o_alu_op=100, o_rd1=0x11, o_valid=1.
//  Load-use: lw x6 in ID/EX, decode rs1=6 -> o_stall_f/d=1 one cycle, bubble inserted,
//   o_bubble_cnt 0->1; next edge captures the held instruction. Same with rd=x0 -> no stall.
//  Flush vs hold: i_ex_pc_src=1 with i_ex_hold=1 and load_use=1 -> o_flush_d=1, stalls 0,
//   o_valid 0 next edge, o_bubble_cnt unchanged.
//  Hold: i_ex_hold=1 for 3 cycles -> registers frozen, o_stall_f/d=1, counter unchanged.
//  Saturation: CNT_W=4, force 17 load-use bubbles -> o_bubble_cnt stops at 4'hF.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register.
// Carries the decode control word and datapath into EX, detects load-use
// hazards against the instruction already in EX, and drives the fetch/decode
// stall and decode flush. Load-use bubbles are counted in a saturating counter.
`timescale 1ns/1ps
module id_ex_stage_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [1:0]      i_result_src,
  input  logic            i_mem_write,
  input  logic            i_reg_write,
  input  logic            i_jmp,
  input  logic            i_branch,
  input  logic [2:0]      i_alu_op,
  input  logic [1:0]      i_alu_src_opa,
  input  logic            i_alu_src_opb,
  input  logic [XLEN-1:0] i_rd1,
  input  logic [XLEN-1:0] i_rd2,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_pc_plus4,
  input  logic [XLEN-1:0] i_imm_ext,
  input  logic [4:0]      i_rs1,
  input  logic [4:0]      i_rs2,
  input  logic [4:0]      i_rd,
  input  logic [2:0]      i_funct3,
  input  logic            i_funct7b5,
  input  logic            i_ex_pc_src,
  input  logic            i_ex_hold,
  output logic [1:0]      o_result_src,
  output logic            o_mem_write,
  output logic            o_reg_write,
  output logic            o_jmp,
  output logic            o_branch,
  output logic [2:0]      o_alu_op,
  output logic [1:0]      o_alu_src_opa,
  output logic            o_alu_src_opb,
  output logic [XLEN-1:0] o_rd1,
  output logic [XLEN-1:0] o_rd2,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic [XLEN-1:0] o_imm_ext,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [4:0]      o_rd,
  output logic [2:0]      o_funct3,
  output logic            o_funct7b5,
  output logic            o_valid,
  output logic            o_stall_f,
  output logic            o_stall_d,
  output logic            o_flush_d,
  output logic [CNT_W-1:0] o_bubble_cnt
);

  // Control (12 bits) + five XLEN data words + rs1/rs2/rd (15) + funct3/funct7b5 (4).
  localparam int W = 31 + 5 * XLEN;

  logic [W-1:0] d_word;
  logic [W-1:0] q_word;
  logic         load_use;
  logic         bubble_on_hazard;

  // The decode fields travel as one word so capture, hold and bubble treat
  // every field identically; a bubble is simply the all-zero word.
  assign d_word = {i_result_src, i_mem_write, i_reg_write, i_jmp, i_branch,
                   i_alu_op, i_alu_src_opa, i_alu_src_opb,
                   i_rd1, i_rd2, i_pc, i_pc_plus4, i_imm_ext,
                   i_rs1, i_rs2, i_rd, i_funct3, i_funct7b5};

  assign {o_result_src, o_mem_write, o_reg_write, o_jmp, o_branch,
          o_alu_op, o_alu_src_opa, o_alu_src_opb,
          o_rd1, o_rd2, o_pc, o_pc_plus4, o_imm_ext,
          o_rs1, o_rs2, o_rd, o_funct3, o_funct7b5} = q_word;

  // A load in EX whose destination is read by the decode instruction.
  // rs1/rs2 are compared regardless of instruction format: a false stall costs
  // one cycle, a missed one corrupts data.
  assign load_use = o_valid & (o_result_src == 2'b01) & (o_rd != 5'd0) &
                    ((o_rd == i_rs1) | (o_rd == i_rs2));

  // Handshake with IF/ID: o_stall_d=1 means decode must present the same
  // instruction again next cycle (it was not taken); o_flush_d=1 means the
  // decode instruction is on a wrong path and IF/ID must become a bubble.
  // A flush overrides any stall so the redirected fetch is never held back.
  assign o_stall_f = (load_use | i_ex_hold) & ~i_ex_pc_src;
  assign o_stall_d = (load_use | i_ex_hold) & ~i_ex_pc_src;
  assign o_flush_d = i_ex_pc_src;

  // A counted bubble is one inserted because of a load-use, not a flush.
  assign bubble_on_hazard = ~i_ex_pc_src & ~i_ex_hold & load_use;

  // Pipeline register: flush, then hold, then load-use bubble, then capture.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      q_word  <= '0;
      o_valid <= 1'b0;
    end else if (i_ex_pc_src) begin
      q_word  <= '0;
      o_valid <= 1'b0;
    end else if (i_ex_hold) begin
      q_word  <= q_word;
      o_valid <= o_valid;
    end else if (load_use) begin
      q_word  <= '0;
      o_valid <= 1'b0;
    end else begin
      q_word  <= d_word;
      o_valid <= 1'b1;
    end
  end

  // Saturating count of load-use bubbles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_bubble_cnt <= '0;
    end else if (bubble_on_hazard && (o_bubble_cnt != {CNT_W{1'b1}})) begin
      o_bubble_cnt <= o_bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: two instances (default counter width and a
// 4-bit counter) share one stimulus stream and are compared each cycle
// against a behavioural model of the ID/EX register.
`timescale 1ns/1ps
module tb_id_ex_stage_reg;

  typedef struct packed {
    logic [1:0]  result_src;
    logic        mem_write;
    logic        reg_write;
    logic        jmp;
    logic        branch;
    logic [2:0]  alu_op;
    logic [1:0]  alu_src_opa;
    logic        alu_src_opb;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] imm_ext;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        funct7b5;
  } dec_t;

  localparam int DW = $bits(dec_t);
  localparam int RW = 1 + DW + 16 + 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dec_t din = '0;
  logic ex_hold = 1'b0;
  logic ex_pc_src = 1'b0;

  wire dec_t    q_a;
  wire dec_t    q_b;
  wire          valid_a, valid_b;
  wire          sf_a, sd_a, fd_a, sf_b, sd_b, fd_b;
  wire [15:0]   cnt_a;
  wire [3:0]    cnt_b;

  id_ex_stage_reg #(.XLEN(32), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_result_src(din.result_src), .i_mem_write(din.mem_write),
    .i_reg_write(din.reg_write), .i_jmp(din.jmp), .i_branch(din.branch),
    .i_alu_op(din.alu_op), .i_alu_src_opa(din.alu_src_opa),
    .i_alu_src_opb(din.alu_src_opb),
    .i_rd1(din.rd1), .i_rd2(din.rd2), .i_pc(din.pc),
    .i_pc_plus4(din.pc_plus4), .i_imm_ext(din.imm_ext),
    .i_rs1(din.rs1), .i_rs2(din.rs2), .i_rd(din.rd),
    .i_funct3(din.funct3), .i_funct7b5(din.funct7b5),
    .i_ex_pc_src(ex_pc_src), .i_ex_hold(ex_hold),
    .o_result_src(q_a.result_src), .o_mem_write(q_a.mem_write),
    .o_reg_write(q_a.reg_write), .o_jmp(q_a.jmp), .o_branch(q_a.branch),
    .o_alu_op(q_a.alu_op), .o_alu_src_opa(q_a.alu_src_opa),
    .o_alu_src_opb(q_a.alu_src_opb),
    .o_rd1(q_a.rd1), .o_rd2(q_a.rd2), .o_pc(q_a.pc),
    .o_pc_plus4(q_a.pc_plus4), .o_imm_ext(q_a.imm_ext),
    .o_rs1(q_a.rs1), .o_rs2(q_a.rs2), .o_rd(q_a.rd),
    .o_funct3(q_a.funct3), .o_funct7b5(q_a.funct7b5),
    .o_valid(valid_a), .o_stall_f(sf_a), .o_stall_d(sd_a),
    .o_flush_d(fd_a), .o_bubble_cnt(cnt_a)
  );

  id_ex_stage_reg #(.XLEN(32), .CNT_W(4)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_result_src(din.result_src), .i_mem_write(din.mem_write),
    .i_reg_write(din.reg_write), .i_jmp(din.jmp), .i_branch(din.branch),
    .i_alu_op(din.alu_op), .i_alu_src_opa(din.alu_src_opa),
    .i_alu_src_opb(din.alu_src_opb),
    .i_rd1(din.rd1), .i_rd2(din.rd2), .i_pc(din.pc),
    .i_pc_plus4(din.pc_plus4), .i_imm_ext(din.imm_ext),
    .i_rs1(din.rs1), .i_rs2(din.rs2), .i_rd(din.rd),
    .i_funct3(din.funct3), .i_funct7b5(din.funct7b5),
    .i_ex_pc_src(ex_pc_src), .i_ex_hold(ex_hold),
    .o_result_src(q_b.result_src), .o_mem_write(q_b.mem_write),
    .o_reg_write(q_b.reg_write), .o_jmp(q_b.jmp), .o_branch(q_b.branch),
    .o_alu_op(q_b.alu_op), .o_alu_src_opa(q_b.alu_src_opa),
    .o_alu_src_opb(q_b.alu_src_opb),
    .o_rd1(q_b.rd1), .o_rd2(q_b.rd2), .o_pc(q_b.pc),
    .o_pc_plus4(q_b.pc_plus4), .o_imm_ext(q_b.imm_ext),
    .o_rs1(q_b.rs1), .o_rs2(q_b.rs2), .o_rd(q_b.rd),
    .o_funct3(q_b.funct3), .o_funct7b5(q_b.funct7b5),
    .o_valid(valid_b), .o_stall_f(sf_b), .o_stall_d(sd_b),
    .o_flush_d(fd_b), .o_bubble_cnt(cnt_b)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [RW-1:0] exp_q[$];

  // Model: what instruction sits in EX, whether it is real, bubbles so far.
  dec_t m_ex = '0;
  logic m_valid = 1'b0;
  int   m_bub = 0;
  dec_t n_ex;
  logic n_valid;
  int   n_bub;
  logic e_stall;
  logic e_flush;
  bit   comb_pending = 1'b0;

  task automatic check(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Registered outputs: one expectation per cycle, sampled after the edge.
  initial begin
    logic [RW-1:0] e;
    logic          ev;
    dec_t          eex;
    logic [15:0]   ec16;
    logic [3:0]    ec4;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        {ev, eex, ec16, ec4} = e;
        check("valid", 256'(valid_a), 256'(ev));
        check("fields", 256'(q_a), 256'(eex));
        check("bubble_cnt", 256'(cnt_a), 256'(ec16));
        check("sat_valid", 256'(valid_b), 256'(ev));
        check("sat_fields", 256'(q_b), 256'(eex));
        check("sat_bubble_cnt", 256'(cnt_b), 256'(ec4));
      end
    end
  end

  // Combinational outputs: checked mid-cycle against the current inputs.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (comb_pending) begin
        check("stall_f", 256'(sf_a), 256'(e_stall));
        check("stall_d", 256'(sd_a), 256'(e_stall));
        check("flush_d", 256'(fd_a), 256'(e_flush));
        check("sat_stall_f", 256'(sf_b), 256'(e_stall));
        check("sat_stall_d", 256'(sd_b), 256'(e_stall));
        check("sat_flush_d", 256'(fd_b), 256'(e_flush));
        comb_pending = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Drive one cycle of inputs on the falling edge and work out, from the
  // pipeline rules, what EX must hold after the next rising edge.
  task automatic drive(input dec_t d, input logic hold, input logic pcs,
                       input logic rstn);
    bit lu;
    logic [15:0] s16;
    logic [3:0]  s4;
    @(negedge clk);
    din = d;
    ex_hold = hold;
    ex_pc_src = pcs;
    rst_n = rstn;
    #1;
    if (!rstn) begin
      m_ex = '0;
      m_valid = 1'b0;
      m_bub = 0;
    end
    lu = m_valid && (m_ex.result_src == 2'b01) && (m_ex.rd != 5'd0) &&
         ((m_ex.rd == d.rs1) || (m_ex.rd == d.rs2));
    e_stall = (lu || hold) && !pcs;
    e_flush = pcs;
    comb_pending = 1'b1;
    n_ex = m_ex;
    n_valid = m_valid;
    n_bub = m_bub;
    if (!rstn) begin
      n_ex = '0; n_valid = 1'b0; n_bub = 0;
    end else if (pcs) begin
      n_ex = '0; n_valid = 1'b0;
    end else if (hold) begin
      n_ex = m_ex;
    end else if (lu) begin
      n_ex = '0; n_valid = 1'b0; n_bub = m_bub + 1;
    end else begin
      n_ex = d; n_valid = 1'b1;
    end
    s16 = (n_bub > 65535) ? 16'hFFFF : 16'(n_bub);
    s4  = (n_bub > 15) ? 4'hF : 4'(n_bub);
    exp_q.push_back({n_valid, n_ex, s16, s4});
  endtask

  task automatic tick();
    @(posedge clk);
    m_ex = n_ex;
    m_valid = n_valid;
    m_bub = n_bub;
    #2;
  endtask

  function automatic dec_t rand_dec();
    dec_t d;
    d.result_src  = 2'($urandom_range(0, 3));
    d.mem_write   = 1'($urandom_range(0, 1));
    d.reg_write   = 1'($urandom_range(0, 1));
    d.jmp         = 1'($urandom_range(0, 1));
    d.branch      = 1'($urandom_range(0, 1));
    d.alu_op      = 3'($urandom_range(0, 7));
    d.alu_src_opa = 2'($urandom_range(0, 3));
    d.alu_src_opb = 1'($urandom_range(0, 1));
    d.rd1         = $urandom;
    d.rd2         = $urandom;
    d.pc          = $urandom;
    d.pc_plus4    = $urandom;
    d.imm_ext     = $urandom;
    d.rs1         = 5'($urandom_range(0, 3));
    d.rs2         = 5'($urandom_range(0, 3));
    d.rd          = 5'($urandom_range(0, 3));
    d.funct3      = 3'($urandom_range(0, 7));
    d.funct7b5    = 1'($urandom_range(0, 1));
    return d;
  endfunction

  function automatic dec_t mk(input logic [1:0] rsrc, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [31:0] rd1);
    dec_t d = '0;
    d.result_src = rsrc;
    d.reg_write  = 1'b1;
    d.rs1 = rs1;
    d.rs2 = rs2;
    d.rd  = rd;
    d.rd1 = rd1;
    return d;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    dec_t d;
    // Reset with random decode fields present.
    repeat (2) begin
      drive(rand_dec(), 1'b0, 1'b0, 1'b0);
      tick();
    end
    check("lit_reset_valid", 256'(valid_a), 256'(0));
    check("lit_reset_rd1", 256'(q_a.rd1), 256'(0));
    check("lit_reset_cnt", 256'(cnt_a), 256'(0));
    check("lit_reset_stall", 256'(sf_a), 256'(0));

    // addi x5, x0, 5 with rd1 = 0x11.
    d = mk(2'b00, 5'd0, 5'd0, 5'd5, 32'h11);
    d.alu_op = 3'b100; d.alu_src_opb = 1'b1; d.imm_ext = 32'd5;
    d.pc = 32'h100; d.pc_plus4 = 32'h104;
    drive(d, 1'b0, 1'b0, 1'b1);
    tick();
    check("lit_addi_rd", 256'(q_a.rd), 256'(5));
    check("lit_addi_alu_op", 256'(q_a.alu_op), 256'(4));
    check("lit_addi_rd1", 256'(q_a.rd1), 256'(32'h11));
    check("lit_addi_valid", 256'(valid_a), 256'(1));

    // lw x6 then add x7, x6, x2: one bubble, then capture.
    drive(mk(2'b01, 5'd5, 5'd0, 5'd6, 32'h0), 1'b0, 1'b0, 1'b1);
    tick();
    drive(mk(2'b00, 5'd6, 5'd2, 5'd7, 32'h77), 1'b0, 1'b0, 1'b1);
    #1;
    check("lit_lu_stall_f", 256'(sf_a), 256'(1));
    check("lit_lu_stall_d", 256'(sd_a), 256'(1));
    tick();
    check("lit_lu_bubble_valid", 256'(valid_a), 256'(0));
    check("lit_lu_cnt", 256'(cnt_a), 256'(1));
    drive(mk(2'b00, 5'd6, 5'd2, 5'd7, 32'h77), 1'b0, 1'b0, 1'b1);
    #1;
    check("lit_lu_released", 256'(sf_a), 256'(0));
    tick();
    check("lit_lu_capture_rd", 256'(q_a.rd), 256'(7));
    check("lit_lu_capture_valid", 256'(valid_a), 256'(1));

    // Load to x0 never stalls.
    drive(mk(2'b01, 5'd1, 5'd0, 5'd0, 32'h0), 1'b0, 1'b0, 1'b1);
    tick();
    drive(mk(2'b00, 5'd0, 5'd0, 5'd8, 32'h0), 1'b0, 1'b0, 1'b1);
    #1;
    check("lit_x0_no_stall", 256'(sf_a), 256'(0));
    tick();
    check("lit_x0_rd", 256'(q_a.rd), 256'(8));

    // Flush beats hold and load-use.
    drive(mk(2'b01, 5'd1, 5'd0, 5'd6, 32'h0), 1'b0, 1'b0, 1'b1);
    tick();
    drive(mk(2'b00, 5'd6, 5'd0, 5'd9, 32'h0), 1'b1, 1'b1, 1'b1);
    #1;
    check("lit_flush_d", 256'(fd_a), 256'(1));
    check("lit_flush_stall", 256'(sf_a), 256'(0));
    tick();
    check("lit_flush_valid", 256'(valid_a), 256'(0));
    check("lit_flush_cnt", 256'(cnt_a), 256'(1));

    // Hold for three cycles freezes EX.
    drive(mk(2'b00, 5'd0, 5'd0, 5'd9, 32'h99), 1'b0, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(rand_dec(), 1'b1, 1'b0, 1'b1);
      #1;
      check("lit_hold_stall", 256'(sf_a), 256'(1));
      tick();
      check("lit_hold_rd", 256'(q_a.rd), 256'(9));
      check("lit_hold_rd1", 256'(q_a.rd1), 256'(32'h99));
    end
    check("lit_hold_cnt", 256'(cnt_a), 256'(1));

    // Seventeen load-use bubbles: 4-bit counter pins at F.
    for (int i = 0; i < 17; i++) begin
      drive(mk(2'b01, 5'd0, 5'd0, 5'd6, 32'h0), 1'b0, 1'b0, 1'b1);
      tick();
      drive(mk(2'b00, 5'd6, 5'd0, 5'd3, 32'h0), 1'b0, 1'b0, 1'b1);
      tick();
    end
    check("lit_sat_cnt4", 256'(cnt_b), 256'(4'hF));
    check("lit_sat_cnt16", 256'(cnt_a), 256'(18));

    // Reset asserted while a load-use stall is pending.
    drive(mk(2'b01, 5'd0, 5'd0, 5'd6, 32'h0), 1'b0, 1'b0, 1'b1);
    tick();
    drive(mk(2'b00, 5'd6, 5'd0, 5'd3, 32'h0), 1'b0, 1'b0, 1'b0);
    #1;
    check("lit_rst_stall", 256'(sf_a), 256'(0));
    tick();
    drive(mk(2'b00, 5'd6, 5'd0, 5'd3, 32'h0), 1'b0, 1'b0, 1'b1);
    tick();
    check("lit_rst_restart_valid", 256'(valid_a), 256'(1));
    check("lit_rst_restart_cnt", 256'(cnt_a), 256'(0));

    // Randomized traffic with occasional resets, holds and flushes.
    for (int i = 0; i < 500; i++) begin
      drive(rand_dec(), 1'($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 49) != 0));
      tick();
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
